// File: rtl/cpu_seq_pkg.sv
// Shared encodings for the multicycle LEGv8 control sequencer: FSM states,
// opcode constants, opcode classes and ALU operation codes.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CLS_R       = 3'd0,
    CLS_SHIFT   = 3'd1,
    CLS_LDUR    = 3'd2,
    CLS_STUR    = 3'd3,
    CLS_CBZ     = 3'd4,
    CLS_B       = 3'd5,
    CLS_ILLEGAL = 3'd6
  } op_class_t;

  localparam logic [10:0] OPC_ADD  = 11'h458;
  localparam logic [10:0] OPC_SUB  = 11'h658;
  localparam logic [10:0] OPC_AND  = 11'h450;
  localparam logic [10:0] OPC_ORR  = 11'h550;
  localparam logic [10:0] OPC_LSL  = 11'h69B;
  localparam logic [10:0] OPC_LSR  = 11'h69A;
  localparam logic [10:0] OPC_LDUR = 11'h7C2;
  localparam logic [10:0] OPC_STUR = 11'h7C0;
  // Branch formats are identified by their prefix bits only.
  localparam logic [7:0]  OPC_CBZ_PREFIX = 8'hB4;
  localparam logic [5:0]  OPC_B_PREFIX   = 6'h05;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_SHIFT  = 2'b10;
  localparam logic [1:0] ALU_OP_RTYPE  = 2'b11;

endpackage

// File: rtl/cpu_sequencer_opcode_classifier.sv
// Combinational opcode classifier: maps instruction[31:21] onto an opcode class.
module opcode_classifier
  import cpu_seq_pkg::*;
(
  input  logic [10:0] opcode,
  output op_class_t   op_class
);

  // Exact encodings first, then the prefix-matched branch formats.
  always_comb begin
    op_class = CLS_ILLEGAL;
    case (opcode)
      OPC_ADD, OPC_SUB, OPC_AND, OPC_ORR: op_class = CLS_R;
      OPC_LSL, OPC_LSR:                   op_class = CLS_SHIFT;
      OPC_LDUR:                           op_class = CLS_LDUR;
      OPC_STUR:                           op_class = CLS_STUR;
      default: begin
        if (opcode[10:3] == OPC_CBZ_PREFIX) begin
          op_class = CLS_CBZ;
        end else if (opcode[10:5] == OPC_B_PREFIX) begin
          op_class = CLS_B;
        end else begin
          op_class = CLS_ILLEGAL;
        end
      end
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multicycle control sequencer (FETCH/DECODE/EXECUTE/MEM/WRITEBACK/HALT).
// Optional memory-wait timeout enabled by defining CPU_SEQ_MEM_TIMEOUT_EN.
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        reg_write,
  output logic        reg2loc,
  output logic        alu_src,
  output logic        mem_to_reg,
  output logic [1:0]  alu_op,
  output logic        instr_done,
  output logic        halted
);

  state_t    state_r;
  state_t    next_state_s;
  op_class_t class_s;
  op_class_t class_r;
  logic      timeout_s;

  opcode_classifier u_classifier (
    .opcode   (opcode),
    .op_class (class_s)
  );

`ifdef CPU_SEQ_MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_r;
  logic             wait_s;

  assign wait_s    = (state_r == ST_FETCH) || (state_r == ST_MEM);
  assign timeout_s = wait_s && !mem_ready && (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

  // Consecutive memory-wait cycles; cleared by mem_ready or leaving the wait state.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (wait_s && !mem_ready && (next_state_s == state_r)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= '0;
    end
  end
`else
  localparam int TIMEOUT_CYCLES_UNUSED = TIMEOUT_CYCLES;
  assign timeout_s = 1'b0;
`endif

  // State register; the opcode class is captured as DECODE ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_FETCH;
      class_r <= CLS_R;
    end else begin
      state_r <= next_state_s;
      if (state_r == ST_DECODE) begin
        class_r <= class_s;
      end else begin
        class_r <= class_r;
      end
    end
  end

  // Next-state and control strobes.
  always_comb begin
    next_state_s = state_r;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    reg_write    = 1'b0;
    reg2loc      = 1'b0;
    alu_src      = 1'b0;
    mem_to_reg   = 1'b0;
    alu_op       = ALU_OP_ADD;
    instr_done   = 1'b0;
    halted       = 1'b0;
    case (state_r)
      ST_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write     = 1'b1;
          pc_write     = 1'b1;
          next_state_s = ST_DECODE;
        end else if (timeout_s) begin
          next_state_s = ST_HALT;
        end else begin
          next_state_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        reg2loc = (class_s == CLS_STUR) || (class_s == CLS_CBZ);
        if (class_s == CLS_ILLEGAL) begin
          next_state_s = ST_HALT;
        end else begin
          next_state_s = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        case (class_r)
          CLS_R: begin
            alu_op       = ALU_OP_RTYPE;
            next_state_s = ST_WRITEBACK;
          end
          CLS_SHIFT: begin
            alu_op       = ALU_OP_SHIFT;
            alu_src      = 1'b1;
            next_state_s = ST_WRITEBACK;
          end
          CLS_LDUR, CLS_STUR: begin
            alu_src      = 1'b1;
            next_state_s = ST_MEM;
          end
          CLS_CBZ: begin
            alu_op       = ALU_OP_BRANCH;
            pc_write     = zero;
            pc_src       = zero;
            instr_done   = 1'b1;
            next_state_s = ST_FETCH;
          end
          CLS_B: begin
            alu_op       = ALU_OP_BRANCH;
            pc_write     = 1'b1;
            pc_src       = 1'b1;
            instr_done   = 1'b1;
            next_state_s = ST_FETCH;
          end
          default: next_state_s = ST_HALT;
        endcase
      end
      ST_MEM: begin
        if (class_r == CLS_STUR) begin
          mem_write = 1'b1;
        end else begin
          mem_read = 1'b1;
        end
        if (mem_ready) begin
          if (class_r == CLS_STUR) begin
            instr_done   = 1'b1;
            next_state_s = ST_FETCH;
          end else begin
            next_state_s = ST_WRITEBACK;
          end
        end else if (timeout_s) begin
          next_state_s = ST_HALT;
        end else begin
          next_state_s = ST_MEM;
        end
      end
      ST_WRITEBACK: begin
        reg_write    = 1'b1;
        mem_to_reg   = (class_r == CLS_LDUR);
        instr_done   = 1'b1;
        next_state_s = ST_FETCH;
      end
      ST_HALT: begin
        halted       = 1'b1;
        next_state_s = ST_HALT;
      end
      default: next_state_s = ST_HALT;
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: per-cycle expected strobe vectors are queued
// by the stimulus and checked by an independent negedge monitor.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] opcode;
  logic        zero;
  logic        mem_ready;
  logic        mem_read, mem_write, ir_write, pc_write, pc_src;
  logic        reg_write, reg2loc, alu_src, mem_to_reg;
  logic [1:0]  alu_op;
  logic        instr_done, halted;

  cpu_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .reg_write  (reg_write),
    .reg2loc    (reg2loc),
    .alu_src    (alu_src),
    .mem_to_reg (mem_to_reg),
    .alu_op     (alu_op),
    .instr_done (instr_done),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  // Vector: mem_read mem_write ir_write pc_write pc_src reg_write reg2loc
  //         alu_src mem_to_reg alu_op[1:0] instr_done halted
  localparam logic [12:0] F_WAIT     = 13'h1000;
  localparam logic [12:0] F_RDY      = 13'h1600;
  localparam logic [12:0] DEC        = 13'h0000;
  localparam logic [12:0] DEC_R2L    = 13'h0040;
  localparam logic [12:0] EX_R       = 13'h000C;
  localparam logic [12:0] EX_SH      = 13'h0028;
  localparam logic [12:0] EX_MEMOP   = 13'h0020;
  localparam logic [12:0] EX_CBZ0    = 13'h0006;
  localparam logic [12:0] EX_TAKEN   = 13'h0306;
  localparam logic [12:0] MEM_LD     = 13'h1000;
  localparam logic [12:0] MEM_ST     = 13'h0800;
  localparam logic [12:0] MEM_ST_RDY = 13'h0802;
  localparam logic [12:0] WB         = 13'h0082;
  localparam logic [12:0] WB_LD      = 13'h0092;
  localparam logic [12:0] HALT       = 13'h0001;

`ifdef CPU_SEQ_MEM_TIMEOUT_EN
  localparam int NWAIT = 15;
`else
  localparam int NWAIT = 20;
`endif

  typedef struct {
    logic [12:0] v;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [12:0] obs;

  assign obs = {mem_read, mem_write, ir_write, pc_write, pc_src, reg_write, reg2loc,
                alu_src, mem_to_reg, alu_op, instr_done, halted};

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e.v) begin
        miscompares++;
        $display("FAIL %s: got %b expected %b", e.name, obs, e.v);
      end
    end
  end

  task automatic step(input logic [10:0] opc, input logic z, input logic rdy,
                      input logic rst, input logic [12:0] e, input string nm);
    exp_t t;
    opcode    = opc;
    zero      = z;
    mem_ready = rdy;
    reset     = rst;
    t.v       = e;
    t.name    = nm;
    exp_q.push_back(t);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    opcode    = 11'h000;
    zero      = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;

    step(11'h458, 1'b0, 1'b0, 1'b0, F_WAIT, "reset_state");
    for (int i = 1; i < NWAIT; i++) step(11'h458, 1'b0, 1'b0, 1'b0, F_WAIT, "fetch_wait");

    // ADD with mem_ready tied high (ignored outside FETCH/MEM)
    step(11'h458, 1'b0, 1'b1, 1'b0, F_RDY, "add_fetch");
    step(11'h458, 1'b0, 1'b1, 1'b0, DEC,   "add_decode");
    step(11'h458, 1'b0, 1'b1, 1'b0, EX_R,  "add_execute");
    step(11'h458, 1'b0, 1'b1, 1'b0, WB,    "add_writeback");

    // SUB: opcode changes to LDUR after DECODE must not matter
    step(11'h658, 1'b0, 1'b1, 1'b0, F_RDY, "sub_fetch");
    step(11'h658, 1'b0, 1'b0, 1'b0, DEC,   "sub_decode");
    step(11'h7C2, 1'b0, 1'b0, 1'b0, EX_R,  "sub_latched_execute");
    step(11'h7C2, 1'b0, 1'b0, 1'b0, WB,    "sub_latched_writeback");

    // LSL
    step(11'h69B, 1'b0, 1'b1, 1'b0, F_RDY, "lsl_fetch");
    step(11'h69B, 1'b0, 1'b0, 1'b0, DEC,   "lsl_decode");
    step(11'h69B, 1'b0, 1'b0, 1'b0, EX_SH, "lsl_execute");
    step(11'h69B, 1'b0, 1'b0, 1'b0, WB,    "lsl_writeback");

    // LDUR with mem_ready delayed 3 cycles in MEM: 8 cycles total
    step(11'h7C2, 1'b0, 1'b1, 1'b0, F_RDY,    "ldur_fetch");
    step(11'h7C2, 1'b0, 1'b0, 1'b0, DEC,      "ldur_decode");
    step(11'h7C2, 1'b0, 1'b0, 1'b0, EX_MEMOP, "ldur_execute");
    for (int i = 0; i < 3; i++) step(11'h7C2, 1'b0, 1'b0, 1'b0, MEM_LD, "ldur_mem_wait");
    step(11'h7C2, 1'b0, 1'b1, 1'b0, MEM_LD,   "ldur_mem_ready");
    step(11'h7C2, 1'b0, 1'b0, 1'b0, WB_LD,    "ldur_writeback");

    // STUR, zero-wait: 4 cycles
    step(11'h7C0, 1'b0, 1'b1, 1'b0, F_RDY,      "stur_fetch");
    step(11'h7C0, 1'b0, 1'b1, 1'b0, DEC_R2L,    "stur_decode");
    step(11'h7C0, 1'b0, 1'b1, 1'b0, EX_MEMOP,   "stur_execute");
    step(11'h7C0, 1'b0, 1'b1, 1'b0, MEM_ST_RDY, "stur_mem");

    // CBZ not taken, then taken
    step(11'h5A0, 1'b0, 1'b1, 1'b0, F_RDY,    "cbz0_fetch");
    step(11'h5A0, 1'b0, 1'b0, 1'b0, DEC_R2L,  "cbz0_decode");
    step(11'h5A0, 1'b0, 1'b0, 1'b0, EX_CBZ0,  "cbz0_execute");
    step(11'h5A7, 1'b1, 1'b1, 1'b0, F_RDY,    "cbz1_fetch");
    step(11'h5A7, 1'b1, 1'b0, 1'b0, DEC_R2L,  "cbz1_decode");
    step(11'h5A7, 1'b1, 1'b0, 1'b0, EX_TAKEN, "cbz1_execute");

    // B, unconditional regardless of zero
    step(11'h0A3, 1'b0, 1'b1, 1'b0, F_RDY,    "b_fetch");
    step(11'h0A3, 1'b0, 1'b0, 1'b0, DEC,      "b_decode");
    step(11'h0A3, 1'b0, 1'b0, 1'b0, EX_TAKEN, "b_execute");

    // STUR interrupted by reset during its memory wait
    step(11'h7C0, 1'b0, 1'b1, 1'b0, F_RDY,    "sturr_fetch");
    step(11'h7C0, 1'b0, 1'b0, 1'b0, DEC_R2L,  "sturr_decode");
    step(11'h7C0, 1'b0, 1'b0, 1'b0, EX_MEMOP, "sturr_execute");
    step(11'h7C0, 1'b0, 1'b0, 1'b0, MEM_ST,   "sturr_mem_wait");
    step(11'h7C0, 1'b0, 1'b0, 1'b1, MEM_ST,   "sturr_mem_reset");
    step(11'h7C0, 1'b0, 1'b0, 1'b0, F_WAIT,   "sturr_after_reset");

    // Illegal opcode halts; HALT absorbs everything until reset
    step(11'h000, 1'b0, 1'b1, 1'b0, F_RDY, "illegal_fetch");
    step(11'h000, 1'b0, 1'b0, 1'b0, DEC,   "illegal_decode");
    for (int i = 0; i < 20; i++) begin
      logic [31:0] k;
      k = 32'(i);
      step(11'(i * 37), k[0], k[1], 1'b0, HALT, "halt_hold");
    end
    step(11'h458, 1'b0, 1'b0, 1'b1, HALT,   "halt_reset_cycle");
    step(11'h458, 1'b0, 1'b0, 1'b0, F_WAIT, "post_halt_reset");

`ifdef CPU_SEQ_MEM_TIMEOUT_EN
    // 16 consecutive FETCH cycles without mem_ready time out into HALT
    for (int i = 0; i < 15; i++) step(11'h458, 1'b0, 1'b0, 1'b0, F_WAIT, "timeout_wait");
    step(11'h458, 1'b0, 1'b0, 1'b0, HALT, "timeout_halt");
    step(11'h458, 1'b0, 1'b1, 1'b0, HALT, "timeout_halt_hold");
`endif

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum mem_ready wait in cycles, used only when CPU_SEQ_MEM_TIMEOUT_EN is defined.
REQ-002 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port opcode, input, 11 bits: instruction[31:21] from the instruction register.
REQ-005 SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-006 SHALL have port mem_ready, input, 1 bit: the memory access completes in the cycle it is high.
REQ-007 SHALL have port mem_read, output, 1 bit: memory read request.
REQ-008 SHALL have port mem_write, output, 1 bit: memory write request.
REQ-009 SHALL have ports ir_write, pc_write and pc_src, output, 1 bit each: latch instruction, update PC, select branch target (1) or PC+4 (0).
REQ-010 SHALL have ports reg_write, reg2loc, alu_src and mem_to_reg, output, 1 bit each: register-file and datapath mux controls.
REQ-011 SHALL have port alu_op, output, 2 bits: 00 D-type add, 01 branch pass-B, 10 shift, 11 R-type.
REQ-012 SHALL have ports instr_done and halted, output, 1 bit each: one-cycle retire pulse and sticky halt flag.

Function
REQ-013 SHALL implement the FSM states FETCH, DECODE, EXECUTE, MEM, WRITEBACK and HALT.
REQ-014 FETCH SHALL hold mem_read=1 until mem_ready; on mem_ready it SHALL assert ir_write=1, pc_write=1 and pc_src=0, then go to DECODE.
REQ-015 DECODE SHALL take one cycle and classify the opcode: R (ADD 458h, SUB 658h, AND 450h, ORR 550h), shift (LSL 69Bh, LSR 69Ah), LDUR 7C2h, STUR 7C0h, CBZ (opcode[10:3]=B4h), B (opcode[10:5]=05h), or illegal.
REQ-016 DECODE SHALL drive reg2loc=1 for STUR and CBZ.
REQ-017 An illegal opcode SHALL move the FSM from DECODE to HALT.
REQ-018 EXECUTE SHALL take one cycle with alu_op set per class: LDUR/STUR 00, CBZ/B 01, shift 10, R 11.
REQ-019 EXECUTE SHALL drive alu_src=1 for LDUR, STUR and shift.
REQ-020 In EXECUTE, CBZ SHALL assert pc_write=1 and pc_src=1 only when zero=1, while B SHALL assert both unconditionally; both SHALL pulse instr_done and go to FETCH.
REQ-021 From EXECUTE, R and shift SHALL go to WRITEBACK, and LDUR/STUR SHALL go to MEM.
REQ-022 MEM SHALL hold mem_read (LDUR) or mem_write (STUR) until mem_ready.
REQ-023 On mem_ready in MEM, LDUR SHALL go to WRITEBACK, and STUR SHALL pulse instr_done and go to FETCH.
REQ-024 WRITEBACK SHALL take one cycle with reg_write=1, mem_to_reg=1 only for LDUR, and instr_done=1, then go to FETCH.
REQ-025 With zero-wait memory, latency SHALL be: R/shift 4 cycles, LDUR 5, STUR 4, CBZ/B 3.
REQ-026 HALT SHALL be absorbing: halted=1, all strobes 0, exit only by reset.
REQ-027 The opcode class SHALL be latched at the end of DECODE, so opcode changes after DECODE have no effect.
REQ-028 mem_read and mem_write SHALL never be high together, and each mem_ready SHALL produce at most one pc_write.
REQ-029 mem_ready high outside FETCH/MEM SHALL be ignored.

Reset
REQ-030 When reset=1 at a clock edge, the state SHALL become FETCH, the latched class R, and any timeout counter 0, overriding all other inputs including an in-flight memory wait.
REQ-031 In the cycle after reset, all outputs SHALL be 0 except mem_read=1; halted=0 and alu_op=00.

Configuration
REQ-032 With CPU_SEQ_MEM_TIMEOUT_EN defined, a counter SHALL count consecutive FETCH/MEM cycles without mem_ready and clear on mem_ready or state exit.
REQ-033 With CPU_SEQ_MEM_TIMEOUT_EN defined, the cycle in which the count reaches TIMEOUT_CYCLES with no mem_ready SHALL move the FSM to HALT; mem_ready in that same cycle wins.
REQ-034 Without CPU_SEQ_MEM_TIMEOUT_EN, no counter logic SHALL exist and waits SHALL be unbounded.

Structure
REQ-035 A shared package cpu_seq_pkg SHALL hold the state encoding, opcode constants, opcode-class encoding and alu_op encodings.
REQ-036 One combinational sub-module, opcode_classifier (opcode in, class out), SHALL implement the REQ-015 decode.

Verification
REQ-037 ADD 458h, mem_ready tied 1 -> FETCH, DECODE, EXECUTE (alu_op=11), WRITEBACK (reg_write=1, instr_done=1); 4 cycles.
REQ-038 LDUR 7C2h, data mem_ready delayed 3 cycles -> mem_read held 4 MEM cycles, then WRITEBACK with mem_to_reg=1; 8 cycles total.
REQ-039 CBZ B4h<<3 with zero=0, then zero=1 -> first: no pc_src=1, 3 cycles; second: pc_write=1 and pc_src=1 in EXECUTE.
REQ-040 Opcode 000h -> HALT after DECODE, halted=1, strobes 0 for 20 cycles; reset -> FETCH, mem_read=1, halted=0.
REQ-041 Reset asserted mid-MEM of STUR -> next cycle FETCH, mem_write=0, no instr_done.
REQ-042 With CPU_SEQ_MEM_TIMEOUT_EN and TIMEOUT_CYCLES=16, mem_ready held 0 in FETCH -> HALT after 16 cycles; mem_ready at cycle 16 -> DECODE, no HALT.
